noise_check: RTL
================

Name: noise_check

Overview:
- Receive-side checker for the 16-bit Fibonacci LFSR noise stream (taps 16,14,13,11; one shift per generator clock).
- Self-synchronises to the incoming words, then flywheels its own prediction and counts mismatching words.
- Sits at the far end of the audio path (loopback from codec ADC, or after a DSP bypass) to qualify bit-exact transport of test noise.

Parameters:
- LOCK_COUNT, 8: consecutive matching words required to declare lock (1..255).
- LOSS_COUNT, 4: consecutive mismatching words while locked that force resync (1..255).
- CNT_W, 32: width of err_count and word_count.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-high reset.
- clear, in, 1: synchronous clear of err_count/word_count; state unaffected.
- in_valid, in, 1: in_data qualifier; one word per asserted cycle, no backpressure.
- in_data, in, 16: received noise word.
- locked, out, 1: high in LOCKED state.
- sync_state, out, 2: current FSM state encoding.
- err_flag, out, 1: one-cycle pulse per mismatching word while locked.
- err_count, out, CNT_W: mismatch count while locked, saturating.
- word_count, out, CNT_W: words checked while locked, saturating.

Behaviour:
- Next-word function: nxt(w) = {w[14:0], w[15]^w[13]^w[12]^w[10]}. Example: nxt(16'hACE1) = 16'h59C3.
- Reset values: state HUNT(0), pred 0, match/miss counters 0, locked 0, err_flag 0, counters 0.
- All outputs are registered. Their response appears the cycle after the in_valid word.
- Cycles with in_valid=0 hold all state; err_flag returns to 0.
- HUNT(0):
  - Valid word w≠0: pred<=nxt(w), match_cnt<=0, go to VERIFY.
  - w==0 (LFSR lockup value): ignored, stay in HUNT.
- VERIFY(1):
  - Valid w==pred: pred<=nxt(w), match_cnt+1. At LOCK_COUNT matches go to LOCKED, miss_cnt<=0.
  - Valid w!=pred: reseed from w as in HUNT and stay in VERIFY (w==0 goes to HUNT).
- LOCKED(2):
  - Every valid word: pred<=nxt(pred) (flywheel, never reseeded from data); word_count+1.
  - Match: miss_cnt<=0.
  - Mismatch: err_flag=1, err_count+1, miss_cnt+1.
  - When miss_cnt reaches LOSS_COUNT: go to HUNT, locked drops on the next cycle. The triggering word is still counted.
- State 3 is unreachable; decoding it forces HUNT.
- Counters saturate at all-ones and never wrap.
- clear together with a counting event: clear wins, counter = 0.
- Errors and words are not counted outside LOCKED.
- Asynchronous reset mid-stream returns to reset values immediately. Reacquisition restarts from HUNT.
- Lock latency from first valid word: LOCK_COUNT+1 valid words; locked high the cycle after the last of them.

Optional Feature:
- Macro NOISE_CHECK_BIT_ERR_EN.
  - Defined: extra output bit_err_count (CNT_W, saturating, cleared by reset/clear). It adds popcount(in_data ^ pred) per locked valid word. Adds at most 16 per word and saturates rather than wrapping.
  - Undefined: port absent, no popcount logic. Word-level behaviour is identical in both builds.

Decomposition:
- Shared package noise_pkg:
  - LFSR_SEED = 16'hACE1, shared with the generator.
  - Tap positions.
  - lfsr16_next function, used by generator and checker so they cannot diverge.
  - sync_state enum {HUNT, VERIFY, LOCKED}.
- Sub-module: popcount16 (combinational, 5-bit out), instantiated only under NOISE_CHECK_BIT_ERR_EN.

Test Plan:
- Generator-to-checker direct, seed ACE1, in_valid=1 every cycle: locked=1 after 9 words; err_count stays 0; word_count increments 1/cycle.
- Locked, replace one word (expected 59C3) with 59C2: one err_flag pulse, err_count=1, locked stays 1. Following words match (flywheel); with BIT_ERR_EN, bit_err_count=1.
- Locked, inject 4 consecutive corrupted words: err_count=4, locked=0 the cycle after the 4th. Relock after 9 further clean words.
- in_data=0000 in HUNT for 20 cycles: state stays HUNT, no counters move. Then a valid stream locks normally.
- in_valid toggled 1/0 alternately with generator gated identically: same lock latency in valid words; idle cycles change nothing.
- Preload counters to all-ones minus 1, inject 3 errors: err_count saturates at all-ones. Assert clear in the same cycle as an error: err_count=0.

Source files
------------

// File: rtl/noise_pkg.sv
// noise_pkg: definitions shared by the noise generator and the noise checker.
//   LFSR_SEED    - power-up seed of the 16-bit Fibonacci LFSR noise source.
//   TAP_*        - feedback tap bit indices (polynomial taps 16,14,13,11).
//   lfsr16_next  - one LFSR shift; the generator and the checker both call this
//                  function, so their sequences cannot drift apart.
//   sync_state_e - checker synchronisation states.
package noise_pkg;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  localparam int unsigned TAP_A = 15;
  localparam int unsigned TAP_B = 13;
  localparam int unsigned TAP_C = 12;
  localparam int unsigned TAP_D = 10;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } sync_state_e;

  function automatic logic [15:0] lfsr16_next(input logic [15:0] w);
    return {w[14:0], w[TAP_A] ^ w[TAP_B] ^ w[TAP_C] ^ w[TAP_D]};
  endfunction

endpackage

// File: rtl/popcount16.sv
// popcount16: combinational count of set bits in a 16-bit word.
//   i_data  [15:0] - word to count.
//   o_count [4:0]  - number of ones in i_data (0..16).
module popcount16 (
  input  logic [15:0] i_data,
  output logic [4:0]  o_count
);

  always_comb begin
    o_count = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      o_count = o_count + {4'd0, i_data[i]};
    end
  end

endmodule

// File: rtl/noise_check.sv
// noise_check: receive-side checker for the 16-bit LFSR test-noise stream.
// Hunts for a non-zero word, verifies LOCK_COUNT consecutive predicted words,
// then flywheels its own prediction and counts mismatching words. LOSS_COUNT
// consecutive mismatches while locked force a resync from HUNT.
//
// Ports:
//   clk, reset      - clock; asynchronous active-high reset.
//   clear           - synchronous clear of the statistics counters only.
//   in_valid        - in_data qualifier, one word per asserted cycle.
//   in_data [15:0]  - received noise word.
//   locked          - high while in LOCKED.
//   sync_state[1:0] - current state encoding (HUNT=0, VERIFY=1, LOCKED=2).
//   err_flag        - one-cycle pulse per mismatching word while locked.
//   err_count       - saturating count of mismatching words while locked.
//   word_count      - saturating count of words checked while locked.
//   bit_err_count   - (NOISE_CHECK_BIT_ERR_EN only) saturating count of
//                     mismatching bits while locked.
//
// Configuration macro: NOISE_CHECK_BIT_ERR_EN enables bit_err_count.
module noise_check
  import noise_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 8,
  parameter int unsigned LOSS_COUNT = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             locked,
  output logic [1:0]       sync_state,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count
`ifdef NOISE_CHECK_BIT_ERR_EN
  ,
  output logic [CNT_W-1:0] bit_err_count
`endif
);

  localparam logic [7:0] LOCK_LIM = 8'(LOCK_COUNT);
  localparam logic [7:0] LOSS_LIM = 8'(LOSS_COUNT);

  sync_state_e      r_state;
  sync_state_e      w_state_nxt;
  logic [15:0]      r_pred;
  logic [15:0]      w_pred_nxt;
  logic [7:0]       r_match_cnt;
  logic [7:0]       w_match_nxt;
  logic [7:0]       r_miss_cnt;
  logic [7:0]       w_miss_nxt;
  logic             r_err_flag;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_word_count;

  logic             w_match;
  logic [15:0]      w_seed;
  logic             w_locked_st;
  logic             w_count_evt;
  logic             w_err_evt;

  assign w_match = (in_data == r_pred);
  assign w_seed  = lfsr16_next(in_data);

  // State register (with the prediction and sync counters it qualifies).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= HUNT;
      r_pred      <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pred      <= w_pred_nxt;
      r_match_cnt <= w_match_nxt;
      r_miss_cnt  <= w_miss_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_pred_nxt  = r_pred;
    w_match_nxt = r_match_cnt;
    w_miss_nxt  = r_miss_cnt;
    case (r_state)
      HUNT: begin
        // Zero is the LFSR lockup value and cannot seed a prediction.
        if (in_valid && (in_data != '0)) begin
          w_pred_nxt  = w_seed;
          w_match_nxt = '0;
          w_state_nxt = VERIFY;
        end
      end
      VERIFY: begin
        if (in_valid) begin
          if (w_match) begin
            w_pred_nxt  = w_seed;
            w_match_nxt = r_match_cnt + 8'd1;
            if ((r_match_cnt + 8'd1) == LOCK_LIM) begin
              w_state_nxt = LOCKED;
              w_miss_nxt  = '0;
            end
          end else if (in_data == '0) begin
            w_state_nxt = HUNT;
          end else begin
            w_pred_nxt  = w_seed;
            w_match_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if (in_valid) begin
          // Flywheel: the prediction never reseeds from received data here.
          w_pred_nxt = lfsr16_next(r_pred);
          if (w_match) begin
            w_miss_nxt = '0;
          end else begin
            w_miss_nxt = r_miss_cnt + 8'd1;
            if ((r_miss_cnt + 8'd1) == LOSS_LIM) begin
              w_state_nxt = HUNT;
            end
          end
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  // Output decode.
  always_comb begin
    w_locked_st = (r_state == LOCKED);
    w_count_evt = w_locked_st && in_valid;
    w_err_evt   = w_count_evt && !w_match;
  end

  // Statistics; clear takes priority over a same-cycle counting event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_flag   <= 1'b0;
      r_err_count  <= '0;
      r_word_count <= '0;
    end else begin
      r_err_flag <= w_err_evt;
      if (clear) begin
        r_err_count <= '0;
      end else if (w_err_evt && (r_err_count != '1)) begin
        r_err_count <= r_err_count + CNT_W'(1);
      end
      if (clear) begin
        r_word_count <= '0;
      end else if (w_count_evt && (r_word_count != '1)) begin
        r_word_count <= r_word_count + CNT_W'(1);
      end
    end
  end

`ifdef NOISE_CHECK_BIT_ERR_EN
  // Sum is wide enough for both the counter and a 5-bit popcount, so a
  // narrow counter still detects overflow instead of truncating the addend.
  localparam int unsigned SUM_W = ((CNT_W > 5) ? CNT_W : 5) + 1;

  logic [15:0]      w_diff;
  logic [4:0]       w_pop;
  logic [SUM_W-1:0] w_bit_sum;
  logic [CNT_W-1:0] r_bit_err_count;

  assign w_diff = in_data ^ r_pred;

  popcount16 u_popcount (
    .i_data  (w_diff),
    .o_count (w_pop)
  );

  assign w_bit_sum = SUM_W'(r_bit_err_count) + SUM_W'(w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_err_count <= '0;
    end else if (clear) begin
      r_bit_err_count <= '0;
    end else if (w_count_evt) begin
      if (w_bit_sum > SUM_W'({CNT_W{1'b1}})) begin
        r_bit_err_count <= '1;
      end else begin
        r_bit_err_count <= w_bit_sum[CNT_W-1:0];
      end
    end
  end

  assign bit_err_count = r_bit_err_count;
`endif

  assign locked     = w_locked_st;
  assign sync_state = r_state;
  assign err_flag   = r_err_flag;
  assign err_count  = r_err_count;
  assign word_count = r_word_count;

endmodule
